// File: rtl/nic_rx_packet_assembler_pkg.sv
// nic_rx_packet_assembler_pkg: shared NIC flit definitions and buffer sizing
package nic_rx_packet_assembler_pkg;
    localparam int FLIT_WIDTH       = 16;
    localparam int MAX_PACKET_FLITS = 5;
    localparam int N_SLOTS          = 2;
    localparam int TYPE_LSB         = 0;
    localparam int TYPE_MSB         = 1;
    localparam int PTR_W            = $clog2(N_SLOTS);
    localparam int CNT_W            = $clog2(N_SLOTS * MAX_PACKET_FLITS + 1);
    localparam int LEN_W            = 3;
    localparam int PKT_W            = FLIT_WIDTH * MAX_PACKET_FLITS;
    typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_e;
    typedef enum logic {IDLE, ASSEMBLING} asm_state_e;
    function automatic flit_type_e flit_type(input logic [FLIT_WIDTH-1:0] f);
        return flit_type_e'(f[TYPE_MSB:TYPE_LSB]);
    endfunction
endpackage

// File: rtl/nic_rx_packet_assembler_credit.sv
// nic_credit_return: credit counter that absorbs add-N bursts and drains one pulse per cycle
module nic_credit_return
    import nic_rx_packet_assembler_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] add_i,
    output logic             credit_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    assign credit_o = cnt_q != '0;
    assign cnt_d    = cnt_q + add_i - WIDTH'(credit_o);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/nic_rx_packet_assembler.sv
// nic_rx_packet_assembler: gathers router flits into a two-slot packet FIFO and
// hands complete packets to the NIC, returning credits for every freed flit.
module nic_rx_packet_assembler
    import nic_rx_packet_assembler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_link_i,
    input  logic                  is_valid_i,
    output logic                  credit_signal_o,
    output logic                  free_signal_o,
    output logic [PKT_W-1:0]      packet_o,
    output logic [LEN_W-1:0]      packet_len_o,
    output logic                  packet_valid_o,
    input  logic                  packet_ready_i,
    output logic                  err_o
);
    asm_state_e            state_q, state_d;
    logic [LEN_W-1:0]      count_q, count_d;
    logic [PTR_W:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PKT_W-1:0]      slot_q [N_SLOTS];
    logic [PKT_W-1:0]      slot_d [N_SLOTS];
    logic [LEN_W-1:0]      len_q [N_SLOTS];
    logic [LEN_W-1:0]      len_d [N_SLOTS];
    logic                  err_q, err_d, free_q, free_d;
    logic [CNT_W-1:0]      credit_add;
    logic [PTR_W-1:0]      widx, ridx;
    logic                  empty, full, pop, restart;
    flit_type_e            ftype;
    logic [FLIT_WIDTH-1:0] flit;
    assign widx    = wptr_q[PTR_W-1:0];
    assign ridx    = rptr_q[PTR_W-1:0];
    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (widx == ridx);
    assign pop     = !empty && packet_ready_i;
    assign ftype   = flit_type(in_link_i);
    assign restart = (ftype == HEAD) || (ftype == HEAD_TAIL);
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q + (PTR_W+1)'(pop);
        slot_d     = slot_q;
        len_d      = len_q;
        err_d      = 1'b0;
        free_d     = pop;
        credit_add = pop ? CNT_W'(len_q[ridx]) : '0;
        flit       = in_link_i;
        if (is_valid_i) begin
            if (state_q == IDLE || restart) begin
                // a head flit abandons any partial packet, then behaves as in IDLE
                state_d = IDLE;
                count_d = '0;
                if (state_q == ASSEMBLING) begin
                    credit_add = credit_add + CNT_W'(count_q);
                    err_d      = 1'b1;
                end
                if (!restart || full) begin
                    credit_add = credit_add + CNT_W'(1);
                    err_d      = 1'b1;
                end else begin
                    slot_d[widx] = PKT_W'(in_link_i);
                    if (ftype == HEAD) begin
                        state_d = ASSEMBLING;
                        count_d = LEN_W'(1);
                    end else begin
                        len_d[widx] = LEN_W'(1);
                        wptr_d      = wptr_q + (PTR_W+1)'(1);
                    end
                end
            end else begin
                if (ftype == BODY && count_q == LEN_W'(MAX_PACKET_FLITS - 1)) begin
                    flit[TYPE_MSB:TYPE_LSB] = TAIL;
                    err_d                   = 1'b1;
                end
                slot_d[widx][int'(count_q)*FLIT_WIDTH +: FLIT_WIDTH] = flit;
                count_d = count_q + LEN_W'(1);
                if (flit_type(flit) == TAIL) begin
                    len_d[widx] = count_d;
                    wptr_d      = wptr_q + (PTR_W+1)'(1);
                    state_d     = IDLE;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            slot_q  <= '{default: '0};
            len_q   <= '{default: '0};
            err_q   <= 1'b0;
            free_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            slot_q  <= slot_d;
            len_q   <= len_d;
            err_q   <= err_d;
            free_q  <= free_d;
        end
    end
    assign packet_valid_o = !empty;
    assign packet_o       = empty ? '0 : slot_q[ridx];
    assign packet_len_o   = empty ? '0 : len_q[ridx];
    assign err_o          = err_q;
    assign free_signal_o  = free_q;
    nic_credit_return #(.WIDTH(CNT_W)) u_credit (
        .clk      (clk),
        .rst      (rst),
        .add_i    (credit_add),
        .credit_o (credit_signal_o)
    );
endmodule

// File: tb/tb_nic_rx_packet_assembler.sv
// tb_nic_rx_packet_assembler: directed stimulus against a queue-based packet model
module tb_nic_rx_packet_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_link_i = '0;
    logic        is_valid_i = 1'b0;
    logic        packet_ready_i = 1'b0;
    logic        credit_signal_o, free_signal_o, packet_valid_o, err_o;
    logic [79:0] packet_o;
    logic [2:0]  packet_len_o;

    nic_rx_packet_assembler dut (
        .clk             (clk),
        .rst             (rst),
        .in_link_i       (in_link_i),
        .is_valid_i      (is_valid_i),
        .credit_signal_o (credit_signal_o),
        .free_signal_o   (free_signal_o),
        .packet_o        (packet_o),
        .packet_len_o    (packet_len_o),
        .packet_valid_o  (packet_valid_o),
        .packet_ready_i  (packet_ready_i),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_cred = 0, n_free = 0;

    function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [79:0] d;
        int          len;
    } pkt_t;

    pkt_t        q[$];
    pkt_t        m_p;
    bit          m_asm = 0, m_err = 0, m_free = 0, m_pop, m_new;
    int          m_cnt = 0, m_pend = 0, m_add;
    logic [79:0] m_buf = '0;
    logic [15:0] m_f;
    logic [1:0]  m_t;

    // Packet-level view: completed packets queue up to two deep, credits are a plain tally
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_asm = 0; m_err = 0; m_free = 0; m_cnt = 0; m_pend = 0; m_buf = '0;
        end else begin
            m_add = 0; m_err = 0; m_free = 0; m_new = 0;
            m_pop = q.size() > 0 && packet_ready_i;
            if (m_pop) begin
                m_add += q[0].len;
                m_free = 1;
            end
            if (is_valid_i) begin
                m_f = in_link_i;
                m_t = m_f[1:0];
                if (m_asm && (m_t == 2'b00 || m_t == 2'b11)) begin
                    m_add += m_cnt;
                    m_err = 1;
                    m_asm = 0;
                end
                if (!m_asm) begin
                    if (m_t == 2'b01 || m_t == 2'b10 || q.size() == 2) begin
                        m_err = 1;
                        m_add += 1;
                    end else if (m_t == 2'b00) begin
                        m_buf = {64'b0, m_f};
                        m_cnt = 1;
                        m_asm = 1;
                    end else begin
                        m_p.d = {64'b0, m_f};
                        m_p.len = 1;
                        m_new = 1;
                    end
                end else begin
                    if (m_t == 2'b01 && m_cnt == 4) begin
                        m_f[1:0] = 2'b10;
                        m_err = 1;
                    end
                    m_buf[m_cnt*16 +: 16] = m_f;
                    m_cnt++;
                    if (m_f[1:0] == 2'b10) begin
                        m_p.d = m_buf;
                        m_p.len = m_cnt;
                        m_new = 1;
                        m_asm = 0;
                    end
                end
            end
            if (m_pop) void'(q.pop_front());
            if (m_new) q.push_back(m_p);
            m_pend = m_pend + m_add - (m_pend > 0 ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        chk("valid", 80'(packet_valid_o), 80'(q.size() > 0));
        chk("len", 80'(packet_len_o), q.size() > 0 ? 80'(q[0].len) : 80'd0);
        chk("packet", packet_o, q.size() > 0 ? q[0].d : 80'd0);
        chk("err", 80'(err_o), 80'(m_err));
        chk("free", 80'(free_signal_o), 80'(m_free));
        chk("credit", 80'(credit_signal_o), 80'(m_pend > 0));
        if (rst && credit_signal_o) n_cred++;
        if (rst && free_signal_o) n_free++;
    end

    task automatic cyc(input logic v, input logic [15:0] f, input logic r);
        is_valid_i = v;
        in_link_i = f;
        packet_ready_i = r;
        @(posedge clk);
        #1;
        is_valid_i = 1'b0;
        packet_ready_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'h0, 1'b0);
    endtask

    int c, f;

    initial begin
        is_valid_i = 1'b1; in_link_i = 16'h6F03; packet_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 80'(packet_valid_o), 80'd0);
        chk("rst_packet", packet_o, 80'd0);
        chk("rst_credit", 80'(credit_signal_o), 80'd0);
        is_valid_i = 1'b0; packet_ready_i = 1'b0;
        rst = 1'b1;
        idle(3);
        chk("post_rst_credits", 80'(n_cred), 80'd0);
        chk("post_rst_valid", 80'(packet_valid_o), 80'd0);

        c = n_cred; f = n_free;
        cyc(1, 16'h6F03, 0);
        chk("ht_valid", 80'(packet_valid_o), 80'd1);
        chk("ht_len", 80'(packet_len_o), 80'd1);
        chk("ht_flit0", 80'(packet_o[15:0]), 80'h6F03);
        cyc(0, 16'h0, 1);
        chk("ht_free", 80'(free_signal_o), 80'd1);
        idle(4);
        chk("ht_credits", 80'(n_cred - c), 80'd1);
        chk("ht_frees", 80'(n_free - f), 80'd1);

        cyc(1, 16'h6F00, 0); cyc(1, 16'hBBB1, 0); cyc(1, 16'hCCC1, 0);
        idle(1);
        cyc(1, 16'hDDD1, 0); cyc(1, 16'hFFF2, 0);
        chk("five_len", 80'(packet_len_o), 80'd5);
        chk("five_packet", packet_o, 80'hFFF2_DDD1_CCC1_BBB1_6F00);
        c = n_cred;
        cyc(0, 16'h0, 1);
        idle(7);
        chk("five_credits", 80'(n_cred - c), 80'd5);

        cyc(1, 16'hA000, 0); cyc(1, 16'hA001, 0); cyc(1, 16'hA002, 0);
        cyc(1, 16'hB000, 0); cyc(1, 16'hB001, 0); cyc(1, 16'hB002, 0);
        chk("bp_head_pkt", packet_o, 80'h0000_0000_A002_A001_A000);
        cyc(1, 16'hC000, 0);
        chk("bp_drop_err", 80'(err_o), 80'd1);
        idle(3);
        c = n_cred; f = n_free;
        cyc(0, 16'h0, 1);
        chk("bp_second_pkt", packet_o, 80'h0000_0000_B002_B001_B000);
        cyc(0, 16'h0, 1);
        idle(8);
        chk("bp_credits", 80'(n_cred - c), 80'd6);
        chk("bp_frees", 80'(n_free - f), 80'd2);
        chk("bp_empty", 80'(packet_valid_o), 80'd0);

        c = n_cred;
        cyc(1, 16'h1231, 0);
        chk("idle_body_err", 80'(err_o), 80'd1);
        idle(3);
        chk("idle_body_credit", 80'(n_cred - c), 80'd1);
        cyc(1, 16'h1110, 0); cyc(1, 16'h3331, 0);
        c = n_cred;
        cyc(1, 16'h2220, 0);
        chk("abandon_err", 80'(err_o), 80'd1);
        cyc(1, 16'h2222, 0);
        chk("restart_len", 80'(packet_len_o), 80'd2);
        chk("restart_packet", packet_o, 80'h2222_2220);
        idle(4);
        chk("abandon_credits", 80'(n_cred - c), 80'd2);
        cyc(0, 16'h0, 1);
        idle(4);

        cyc(1, 16'h4440, 0);
        repeat (3) cyc(1, 16'h4441, 0);
        chk("ovl_no_err_yet", 80'(err_o), 80'd0);
        cyc(1, 16'h4441, 0);
        chk("ovl_err", 80'(err_o), 80'd1);
        chk("ovl_len", 80'(packet_len_o), 80'd5);
        chk("ovl_packet", packet_o, 80'h4442_4441_4441_4441_4440);
        cyc(1, 16'h5550, 0); cyc(1, 16'h5552, 0);
        c = n_cred;
        cyc(0, 16'h0, 1);
        cyc(0, 16'h0, 1);
        chk("ovl_drained_fifo", 80'(packet_valid_o), 80'd0);
        idle(10);
        chk("overlap_credits", 80'(n_cred - c), 80'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
